// File: rtl/systolic_feed_sequencer_pkg.sv
// rtl/systolic_feed_sequencer_pkg.sv - shared state encoding and default sizes for the feed sequencer
package systolic_feed_sequencer_pkg;

  localparam int DEF_ARRAY_DIM = 256;
  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_ROW_AW    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/systolic_feed_sequencer_if.sv
// rtl/systolic_feed_sequencer_if.sv - control, buffer-read and array-feed signals of the feed sequencer
interface systolic_feed_sequencer_if
  import systolic_feed_sequencer_pkg::*;
#(
  parameter int ARRAY_DIM = DEF_ARRAY_DIM,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ROW_AW    = DEF_ROW_AW
);
  localparam int W_AW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;

  logic                           start;
  logic [ROW_AW-1:0]              num_rows;
  logic                           busy;
  logic                           done;
  logic                           w_rd_en;
  logic [W_AW-1:0]                w_rd_addr;
  logic [ARRAY_DIM*DATA_SIZE-1:0] w_rd_data;
  logic [ARRAY_DIM-1:0]           w_load_en;
  logic [ARRAY_DIM*DATA_SIZE-1:0] w_load_data;
  logic                           v_rd_en;
  logic [ROW_AW-1:0]              v_rd_addr;
  logic [ARRAY_DIM*DATA_SIZE-1:0] v_rd_data;
  logic [ARRAY_DIM-1:0]           west_full;
  logic [ARRAY_DIM-1:0]           west_wr_en;
  logic [ARRAY_DIM*DATA_SIZE-1:0] west_data;
  logic                           array_en;

  modport master (
    input  start, num_rows, w_rd_data, v_rd_data, west_full,
    output busy, done, w_rd_en, w_rd_addr, w_load_en, w_load_data,
           v_rd_en, v_rd_addr, west_wr_en, west_data, array_en
  );

  modport slave (
    output start, num_rows, w_rd_data, v_rd_data, west_full,
    input  busy, done, w_rd_en, w_rd_addr, w_load_en, w_load_data,
           v_rd_en, v_rd_addr, west_wr_en, west_data, array_en
  );

endinterface

// File: rtl/systolic_feed_sequencer_skew.sv
// rtl/systolic_feed_sequencer_skew.sv - skew_delay_line: lane r delays its element by r advances
module skew_delay_line #(
  parameter int LANES     = 4,
  parameter int DATA_SIZE = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       advance,
  input  logic                       in_valid,
  input  logic [LANES*DATA_SIZE-1:0] in_data,
  output logic [LANES-1:0]           out_valid,
  output logic [LANES*DATA_SIZE-1:0] out_data,
  output logic                       pending
);

  logic [LANES-1:0] lane_pend;

  for (genvar r = 0; r < LANES; r++) begin : g_lane
    if (r == 0) begin : g_pass
      assign out_valid[0]             = in_valid;
      assign out_data[0 +: DATA_SIZE] = in_data[0 +: DATA_SIZE];
      assign lane_pend[0]             = 1'b0;
    end else begin : g_chain
      logic [r-1:0]           vq;
      logic [r*DATA_SIZE-1:0] dq;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vq <= '0;
          dq <= '0;
        end else if (advance) begin
          vq[0]              <= in_valid;
          dq[0 +: DATA_SIZE] <= in_data[r*DATA_SIZE +: DATA_SIZE];
          for (int s = 1; s < r; s++) begin
            vq[s]                      <= vq[s-1];
            dq[s*DATA_SIZE +: DATA_SIZE] <= dq[(s-1)*DATA_SIZE +: DATA_SIZE];
          end
        end
      end

      assign out_valid[r]                     = vq[r-1];
      assign out_data[r*DATA_SIZE +: DATA_SIZE] = dq[(r-1)*DATA_SIZE +: DATA_SIZE];
      assign lane_pend[r]                     = |vq;
    end
  end

  assign pending = |lane_pend;

endmodule

// File: rtl/systolic_feed_sequencer.sv
// rtl/systolic_feed_sequencer.sv - sequences weight load, skewed value streaming and drain for one systolic pass
module systolic_feed_sequencer
  import systolic_feed_sequencer_pkg::*;
#(
  parameter int ARRAY_DIM = DEF_ARRAY_DIM,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ROW_AW    = DEF_ROW_AW
) (
  input logic                    clk,
  input logic                    reset,
  systolic_feed_sequencer_if.master bus
);

  localparam int D    = ARRAY_DIM;
  localparam int W_AW = (D > 1) ? $clog2(D) : 1;
  localparam int DC_W = $clog2(2 * D);
  localparam logic [W_AW:0]   K_LAST     = (W_AW + 1)'(D);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(2 * D - 2);
  localparam logic [D-1:0]    LANE0      = {{(D-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [W_AW:0]          k_cnt;
  logic [ROW_AW-1:0]      row_cnt, rows_q;
  logic [DC_W-1:0]        drain_cnt;
  logic [D-1:0]           wl_q;
  logic                   rd_pend, skid_v, entry_v;
  logic [D*DATA_SIZE-1:0] skid_d, entry_d;
  logic                   stall, adv, chain_pend, pipe_empty;
  logic                   w_rd_en_c, v_rd_en_c;
  logic [D-1:0]           lane_valid;
  logic [D*DATA_SIZE-1:0] lane_data;

  assign stall      = |bus.west_full;
  assign adv        = ~stall;
  assign pipe_empty = ~(rd_pend | skid_v | entry_v | chain_pend);

  always_comb begin
    state_d   = state_q;
    w_rd_en_c = 1'b0;
    v_rd_en_c = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (bus.start) state_d = (bus.num_rows == '0) ? ST_DONE : ST_LOAD_W;
      ST_LOAD_W: begin
        w_rd_en_c = (k_cnt != K_LAST);
        if (k_cnt == K_LAST) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        v_rd_en_c = adv;
        if (adv && row_cnt == rows_q - ROW_AW'(1)) state_d = ST_DRAIN;
      end
      // Flush waits on the pipeline; the hold-off count then runs regardless of stall.
      ST_DRAIN:  if (pipe_empty && drain_cnt == DRAIN_LAST) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_cnt     <= '0;
      row_cnt   <= '0;
      rows_q    <= '0;
      drain_cnt <= '0;
      wl_q      <= '0;
      rd_pend   <= 1'b0;
    end else begin
      k_cnt     <= (state_q == ST_LOAD_W) ? k_cnt + 1'b1 : '0;
      drain_cnt <= (state_q == ST_DRAIN && pipe_empty) ? drain_cnt + 1'b1 : '0;
      wl_q      <= w_rd_en_c ? (LANE0 << k_cnt) : '0;
      rd_pend   <= v_rd_en_c;
      if (state_q == ST_IDLE) begin
        row_cnt <= '0;
        if (bus.start) rows_q <= bus.num_rows;
      end else if (v_rd_en_c) begin
        row_cnt <= row_cnt + 1'b1;
      end
    end
  end

  // A vector arriving while stalled parks in the skid register and enters on the next advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_v  <= 1'b0;
      skid_d  <= '0;
      entry_v <= 1'b0;
      entry_d <= '0;
    end else if (adv) begin
      if (skid_v) begin
        entry_v <= 1'b1;
        entry_d <= skid_d;
        skid_v  <= 1'b0;
      end else if (rd_pend) begin
        entry_v <= 1'b1;
        entry_d <= bus.v_rd_data;
      end else begin
        entry_v <= 1'b0;
      end
    end else if (rd_pend) begin
      skid_v <= 1'b1;
      skid_d <= bus.v_rd_data;
    end
  end

  skew_delay_line #(
    .LANES     (D),
    .DATA_SIZE (DATA_SIZE)
  ) u_skew (
    .clk       (clk),
    .reset     (reset),
    .advance   (adv),
    .in_valid  (entry_v),
    .in_data   (entry_d),
    .out_valid (lane_valid),
    .out_data  (lane_data),
    .pending   (chain_pend)
  );

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.array_en    = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign bus.w_rd_en     = w_rd_en_c;
  assign bus.w_rd_addr   = w_rd_en_c ? k_cnt[W_AW-1:0] : '0;
  assign bus.w_load_en   = wl_q;
  // The weight buffer output is already registered; forward it only on load cycles.
  assign bus.w_load_data = (|wl_q) ? bus.w_rd_data : '0;
  assign bus.v_rd_en     = v_rd_en_c;
  assign bus.v_rd_addr   = v_rd_en_c ? row_cnt : '0;
  assign bus.west_wr_en  = lane_valid & {D{adv}};
  assign bus.west_data   = lane_data;

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// tb/tb_systolic_feed_sequencer.sv - randomized self-checking bench for systolic_feed_sequencer
module tb_systolic_feed_sequencer;
  import systolic_feed_sequencer_pkg::*;

  localparam int D  = 4;
  localparam int DS = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_feed_sequencer_if #(.ARRAY_DIM(D), .DATA_SIZE(DS), .ROW_AW(AW)) bus ();

  systolic_feed_sequencer #(.ARRAY_DIM(D), .DATA_SIZE(DS), .ROW_AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [D*DS-1:0] wmem [D];
  logic [31:0]     vseed;

  function automatic logic [D*DS-1:0] vrow(input int unsigned a);
    logic [31:0] h;
    h = (a * 32'h9E3779B1) ^ vseed;
    h = h ^ (h >> 13);
    return h;
  endfunction

  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_rd_data <= wmem[bus.w_rd_addr];
    if (bus.v_rd_en) bus.v_rd_data <= vrow(int'(bus.v_rd_addr));
  end

  int          wrd_cyc_q[$], wrd_addr_q[$], wl_cyc_q[$], vrd_cyc_q[$], vrd_addr_q[$], done_q[$], ucyc[$];
  logic [D-1:0]    wl_en_q[$];
  logic [D*DS-1:0] wl_dat_q[$];
  int          wr_lane_q[$], wr_cyc_q[$];
  logic [DS-1:0] wr_dat_q[$];
  int          ae_cnt, ae_first, ae_last, busy_cnt, stall_wr;
  logic        rst_any, rst_busy;

  task automatic run_pass(input int n, input int mode, input int restart_c, input int reset_c, input int limit);
    logic [D-1:0] full;
    wrd_cyc_q.delete(); wrd_addr_q.delete(); wl_cyc_q.delete(); wl_en_q.delete(); wl_dat_q.delete();
    vrd_cyc_q.delete(); vrd_addr_q.delete(); done_q.delete(); ucyc.delete();
    wr_lane_q.delete(); wr_cyc_q.delete(); wr_dat_q.delete();
    ae_cnt = 0; ae_first = -1; ae_last = -1; busy_cnt = 0; stall_wr = 0;
    rst_any = 1'b1; rst_busy = 1'b1;
    bus.num_rows = AW'(n);
    for (int c = 0; c < limit; c++) begin
      bus.start = (c == 0) || (c == restart_c);
      if (mode == 1)      full = (c == 9 || c == 10) ? D'(4) : '0;
      else if (mode == 2) full = ($urandom_range(0, 3) == 0) ? D'($urandom_range(1, 15)) : '0;
      else                full = '0;
      bus.west_full = full;
      if (c >= D + 2 && full == '0) ucyc.push_back(c);
      if (c == reset_c) reset = 1'b1;
      @(negedge clk);
      if (c == reset_c) begin
        rst_any  = |{bus.busy, bus.done, bus.w_rd_en, bus.w_rd_addr, bus.w_load_en, bus.w_load_data,
                     bus.v_rd_en, bus.v_rd_addr, bus.west_wr_en, bus.west_data, bus.array_en};
        rst_busy = bus.busy;
        break;
      end
      if (bus.w_rd_en) begin wrd_cyc_q.push_back(c); wrd_addr_q.push_back(int'(bus.w_rd_addr)); end
      if (|bus.w_load_en) begin wl_cyc_q.push_back(c); wl_en_q.push_back(bus.w_load_en); wl_dat_q.push_back(bus.w_load_data); end
      if (bus.v_rd_en) begin vrd_cyc_q.push_back(c); vrd_addr_q.push_back(int'(bus.v_rd_addr)); end
      if (bus.done) done_q.push_back(c);
      if (bus.busy) busy_cnt++;
      if (bus.array_en) begin
        if (ae_cnt == 0) ae_first = c;
        ae_last = c;
        ae_cnt++;
      end
      if ((|bus.west_full) && (|bus.west_wr_en)) stall_wr++;
      for (int r = 0; r < D; r++)
        if (bus.west_wr_en[r]) begin
          wr_lane_q.push_back(r); wr_cyc_q.push_back(c); wr_dat_q.push_back(bus.west_data[r*DS +: DS]);
        end
      @(posedge clk); #1;
      if (done_q.size() > 0 && c >= done_q[0] + 3) break;
    end
    bus.start = 1'b0;
    bus.west_full = '0;
  endtask

  // Lane r must write row j, byte r, at the (j+r+2)-th unstalled cycle counted from the start of streaming.
  function automatic int lane_errors(input int n);
    int cnt [D];
    int e, r, j, ec;
    logic [D*DS-1:0] row;
    e = 0;
    for (int i = 0; i < D; i++) cnt[i] = 0;
    for (int i = 0; i < wr_lane_q.size(); i++) begin
      r = wr_lane_q[i];
      j = cnt[r];
      if (j >= n) e++;
      else begin
        ec  = (j + r + 2 < ucyc.size()) ? ucyc[j + r + 2] : -1;
        row = vrow(j);
        if (wr_cyc_q[i] != ec || wr_dat_q[i] != row[r*DS +: DS]) e++;
      end
      cnt[r]++;
    end
    for (int i = 0; i < D; i++) if (cnt[i] != n) e++;
    return e;
  endfunction

  function automatic int model_done(input int n);
    return (ucyc.size() > n + D) ? ucyc[n + D] + 2 * D : -1;
  endfunction

  task automatic new_data();
    for (int k = 0; k < D; k++) wmem[k] = $urandom;
    vseed = $urandom;
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else pass_cnt++;
    chk_cnt++;
    if ({bus.done, bus.w_rd_en, bus.v_rd_en, bus.array_en, bus.w_load_en, bus.west_wr_en} !== '0)
      $display("FAIL reset_strobes got=%b want=0", {bus.done, bus.w_rd_en, bus.v_rd_en, bus.array_en, bus.w_load_en, bus.west_wr_en});
    else pass_cnt++;
    chk_cnt++;
    if ({bus.west_data, bus.w_load_data, bus.v_rd_addr, bus.w_rd_addr} !== '0)
      $display("FAIL reset_data got=%h want=0", {bus.west_data, bus.w_load_data, bus.v_rd_addr, bus.w_rd_addr});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int e;
    new_data();
    run_pass(3, 0, -1, -1, 200);
    chk_cnt++;
    if (wrd_cyc_q.size() !== D) $display("FAIL basic_wrd_count got=%0d want=%0d", wrd_cyc_q.size(), D); else pass_cnt++;
    e = 0;
    for (int k = 0; k < wrd_cyc_q.size(); k++) if (wrd_cyc_q[k] != 1 + k || wrd_addr_q[k] != k) e++;
    chk_cnt++;
    if (e !== 0) $display("FAIL basic_wrd_seq bad=%0d want=0", e); else pass_cnt++;
    e = 0;
    for (int k = 0; k < wl_cyc_q.size(); k++)
      if (wl_cyc_q[k] != 2 + k || wl_en_q[k] != D'(1 << k) || wl_dat_q[k] != wmem[k % D]) e++;
    chk_cnt++;
    if (e !== 0 || wl_cyc_q.size() !== D) $display("FAIL basic_wload bad=%0d count=%0d want=0/%0d", e, wl_cyc_q.size(), D); else pass_cnt++;
    e = 0;
    for (int j = 0; j < vrd_cyc_q.size(); j++) if (vrd_cyc_q[j] != 6 + j || vrd_addr_q[j] != j) e++;
    chk_cnt++;
    if (e !== 0 || vrd_cyc_q.size() !== 3) $display("FAIL basic_vrd bad=%0d count=%0d want=0/3", e, vrd_cyc_q.size()); else pass_cnt++;
    chk_cnt++;
    e = lane_errors(3);
    if (e !== 0) $display("FAIL basic_lanes bad=%0d want=0", e); else pass_cnt++;
    chk_cnt++;
    if (done_q.size() !== 1 || done_q[0] !== 21) $display("FAIL basic_done n=%0d cyc=%0d want=1/21", done_q.size(), done_q[0]); else pass_cnt++;
    chk_cnt++;
    if (ae_first !== 6 || ae_last !== 20 || ae_cnt !== 15) $display("FAIL basic_array_en first=%0d last=%0d n=%0d want=6/20/15", ae_first, ae_last, ae_cnt); else pass_cnt++;
    chk_cnt++;
    if (busy_cnt !== 21) $display("FAIL basic_busy got=%0d want=21", busy_cnt); else pass_cnt++;
  endtask

  task automatic test_stall();
    int e;
    new_data();
    run_pass(3, 1, -1, -1, 200);
    chk_cnt++;
    if (stall_wr !== 0) $display("FAIL stall_writes got=%0d want=0", stall_wr); else pass_cnt++;
    chk_cnt++;
    e = lane_errors(3);
    if (e !== 0) $display("FAIL stall_lanes bad=%0d want=0", e); else pass_cnt++;
    chk_cnt++;
    if (done_q.size() !== 1 || done_q[0] !== 23) $display("FAIL stall_done n=%0d cyc=%0d want=1/23", done_q.size(), done_q[0]); else pass_cnt++;
  endtask

  task automatic test_empty();
    new_data();
    run_pass(0, 0, -1, -1, 50);
    chk_cnt++;
    if (done_q.size() !== 1 || done_q[0] !== 1) $display("FAIL empty_done n=%0d cyc=%0d want=1/1", done_q.size(), done_q[0]); else pass_cnt++;
    chk_cnt++;
    if (wrd_cyc_q.size() + vrd_cyc_q.size() + ae_cnt !== 0)
      $display("FAIL empty_activity wrd=%0d vrd=%0d ae=%0d want=0", wrd_cyc_q.size(), vrd_cyc_q.size(), ae_cnt);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    int e;
    new_data();
    run_pass(3, 0, 7, -1, 200);
    chk_cnt++;
    if (done_q.size() !== 1 || done_q[0] !== 21) $display("FAIL restart_done n=%0d cyc=%0d want=1/21", done_q.size(), done_q[0]); else pass_cnt++;
    e = 0;
    for (int j = 0; j < vrd_addr_q.size(); j++) if (vrd_addr_q[j] != j) e++;
    chk_cnt++;
    if (e !== 0 || vrd_addr_q.size() !== 3) $display("FAIL restart_vrd bad=%0d count=%0d want=0/3", e, vrd_addr_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int e;
    new_data();
    run_pass(3, 0, -1, 9, 200);
    chk_cnt++;
    if (rst_any !== 1'b0 || rst_busy !== 1'b0) $display("FAIL midreset_outputs any=%b busy=%b want=0/0", rst_any, rst_busy); else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    run_pass(3, 0, -1, -1, 200);
    chk_cnt++;
    e = lane_errors(3);
    if (e !== 0 || wrd_cyc_q.size() !== D) $display("FAIL midreset_rerun bad=%0d wrd=%0d want=0/%0d", e, wrd_cyc_q.size(), D); else pass_cnt++;
    chk_cnt++;
    if (done_q.size() !== 1 || done_q[0] !== 21) $display("FAIL midreset_done n=%0d cyc=%0d want=1/21", done_q.size(), done_q[0]); else pass_cnt++;
  endtask

  task automatic test_random();
    int n, md, e, ed;
    for (int it = 0; it < 6; it++) begin
      new_data();
      n  = $urandom_range(1, 24);
      md = (it % 2 == 0) ? 2 : 0;
      run_pass(n, md, -1, -1, 600);
      ed = model_done(n);
      chk_cnt++;
      e = lane_errors(n);
      if (e !== 0 || stall_wr !== 0) $display("FAIL rand%0d_lanes n=%0d bad=%0d stallwr=%0d want=0/0", it, n, e, stall_wr); else pass_cnt++;
      chk_cnt++;
      if (done_q.size() !== 1 || done_q[0] !== ed) $display("FAIL rand%0d_done n=%0d cnt=%0d cyc=%0d want=1/%0d", it, n, done_q.size(), done_q[0], ed); else pass_cnt++;
      chk_cnt++;
      if (ae_first !== D + 2 || ae_cnt !== ed - (D + 2)) $display("FAIL rand%0d_array_en first=%0d n=%0d want=%0d/%0d", it, ae_first, ae_cnt, D + 2, ed - (D + 2)); else pass_cnt++;
    end
  endtask

  task automatic test_max_rows();
    int e, zeros;
    new_data();
    run_pass(65535, 0, -1, -1, 66000);
    zeros = 0;
    e = 0;
    for (int j = 0; j < vrd_addr_q.size(); j++) begin
      if (vrd_addr_q[j] == 0) zeros++;
      if (vrd_addr_q[j] != j) e++;
    end
    chk_cnt++;
    if (vrd_addr_q.size() !== 65535 || e !== 0 || zeros !== 1)
      $display("FAIL max_vrd count=%0d bad=%0d zeros=%0d want=65535/0/1", vrd_addr_q.size(), e, zeros);
    else pass_cnt++;
    chk_cnt++;
    if (vrd_addr_q.size() == 0 || vrd_addr_q[vrd_addr_q.size() - 1] !== 32'hFFFE)
      $display("FAIL max_last_addr got=%0h want=fffe", (vrd_addr_q.size() == 0) ? -1 : vrd_addr_q[vrd_addr_q.size() - 1]);
    else pass_cnt++;
    chk_cnt++;
    if (done_q.size() !== 1 || done_q[0] !== model_done(65535)) $display("FAIL max_done n=%0d cyc=%0d want=1/%0d", done_q.size(), done_q[0], model_done(65535)); else pass_cnt++;
    chk_cnt++;
    e = lane_errors(65535);
    if (e !== 0) $display("FAIL max_lanes bad=%0d want=0", e); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.num_rows = '0;
    bus.west_full = '0;
    bus.w_rd_data = '0;
    bus.v_rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_stall();
    test_empty();
    test_restart();
    test_reset_mid();
    test_random();
    test_max_rows();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
